hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none

`ifndef ASIZE
`define ASIZE 5
`endif

// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard detection and stall control. Detects load-use,
//            branch-after-ALU and branch-after-load hazards against the
//            instruction in ID, freezes PC/IF-ID and bubbles ID/EXE while
//            stalled, squashes IF/ID on a taken branch and keeps a saturating
//            count of stalled cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               in   pipeline clock
//   rst               in   asynchronous active-low reset
//   rs_IF_ID/rt_IF_ID in   source registers of the ID instruction
//   rd_ID_EXE         in   destination of the EXE instruction
//   wen_ID_EXE        in   EXE instruction writes the register file
//   mem_read_ID_EXE   in   EXE instruction is a load
//   rd_EXE_MEM        in   destination of the MEM instruction
//   mem_read_EXE_MEM  in   MEM instruction is a load
//   branch_ID         in   ID instruction is a branch resolved in ID
//   take_branch       in   ID branch resolved taken
//   cnt_clr           in   synchronous clear of stall_cycles
//   pc_wen/if_id_wen  out  PC and IF/ID write enables
//   bubble_ID_EXE     out  zero control fields entering ID/EXE
//   flush_IF_ID       out  squash the IF/ID instruction
//   stall_cycles      out  saturating stalled-cycle count
// ============================================================================
module hazard_ctrl #(
    parameter int ASIZE = `ASIZE,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] rs_IF_ID,
    input  logic [ASIZE-1:0] rt_IF_ID,
    input  logic [ASIZE-1:0] rd_ID_EXE,
    input  logic             wen_ID_EXE,
    input  logic             mem_read_ID_EXE,
    input  logic [ASIZE-1:0] rd_EXE_MEM,
    input  logic             mem_read_EXE_MEM,
    input  logic             branch_ID,
    input  logic             take_branch,
    input  logic             cnt_clr,
    output logic             pc_wen,
    output logic             if_id_wen,
    output logic             bubble_ID_EXE,
    output logic             flush_IF_ID,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [0:0]       c_RUN     = 1'b0;
    localparam logic [0:0]       c_STALL   = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [1:0]       r_rem;
    logic [1:0]       w_rem_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic       w_match_exe;
    logic       w_match_mem;
    logic [1:0] w_need;
    logic       w_stall;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    assign w_match_exe = (rd_ID_EXE != '0) &&
                         ((rd_ID_EXE == rs_IF_ID) || (rd_ID_EXE == rt_IF_ID));
    assign w_match_mem = (rd_EXE_MEM != '0) &&
                         ((rd_EXE_MEM == rs_IF_ID) || (rd_EXE_MEM == rt_IF_ID));

    // A branch waiting on a load still in EXE needs the load to reach WB-side
    // forwarding, hence two bubbles; every other hazard needs one.
    always_comb begin
        w_need = 2'd0;
        if (branch_ID && mem_read_ID_EXE && w_match_exe) begin
            w_need = 2'd2;
        end else if ((mem_read_ID_EXE && w_match_exe) ||
                     (branch_ID && wen_ID_EXE && !mem_read_ID_EXE && w_match_exe) ||
                     (branch_ID && mem_read_EXE_MEM && w_match_mem)) begin
            w_need = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_RUN;
            r_rem   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Stall in RUN is combinational so the very cycle of detection is frozen;
    // STALL covers only the extra cycles and ignores the hazard inputs.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stall     = 1'b0;
        case (r_state)
            c_RUN: begin
                w_stall = (w_need != 2'd0);
                if (w_need == 2'd2) begin
                    w_state_nxt = c_STALL;
                    w_rem_nxt   = 2'd1;
                end
            end
            c_STALL: begin
                w_stall   = 1'b1;
                w_rem_nxt = r_rem - 2'd1;
                if (r_rem <= 2'd1) begin
                    w_state_nxt = c_RUN;
                    w_rem_nxt   = 2'd0;
                end
            end
            default: begin
                w_state_nxt = c_RUN;
                w_rem_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (cnt_clr) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != c_CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign pc_wen        = !w_stall;
    assign if_id_wen     = !w_stall;
    assign bubble_ID_EXE = w_stall;
    // The branch outcome is computed from operands that are not valid yet
    // while stalled, so a taken indication then must not squash IF/ID.
    assign flush_IF_ID   = take_branch && !w_stall;
    assign stall_cycles  = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none

// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl (CNT_W = 4). A behavioural
//            model tracks pending stall cycles and the saturating count and
//            is compared with the DUT every cycle; directed sequences pin
//            load-use, zero register, branch-on-load, taken-branch flushing,
//            saturation/clear and reset during a stall with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int ASIZE   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [ASIZE-1:0] rs_IF_ID, rt_IF_ID, rd_ID_EXE, rd_EXE_MEM;
    logic             wen_ID_EXE, mem_read_ID_EXE, mem_read_EXE_MEM;
    logic             branch_ID, take_branch, cnt_clr;
    logic             pc_wen, if_id_wen, bubble_ID_EXE, flush_IF_ID;
    logic [CNT_W-1:0] stall_cycles;

    int n_compared = 0;
    int n_failed   = 0;

    // Model state: stall cycles still owed from an earlier detection, and count.
    int m_extra = 0;
    int m_cnt   = 0;
    int n_extra = 0;
    int n_cnt   = 0;

    hazard_ctrl #(.ASIZE(ASIZE), .CNT_W(CNT_W)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .rs_IF_ID         (rs_IF_ID),
        .rt_IF_ID         (rt_IF_ID),
        .rd_ID_EXE        (rd_ID_EXE),
        .wen_ID_EXE       (wen_ID_EXE),
        .mem_read_ID_EXE  (mem_read_ID_EXE),
        .rd_EXE_MEM       (rd_EXE_MEM),
        .mem_read_EXE_MEM (mem_read_EXE_MEM),
        .branch_ID        (branch_ID),
        .take_branch      (take_branch),
        .cnt_clr          (cnt_clr),
        .pc_wen           (pc_wen),
        .if_id_wen        (if_id_wen),
        .bubble_ID_EXE    (bubble_ID_EXE),
        .flush_IF_ID      (flush_IF_ID),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_failed++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic bit dep(input logic [ASIZE-1:0] r);
        return (r != 0) && (r == rs_IF_ID || r == rt_IF_ID);
    endfunction

    // Number of bubbles the ID instruction requires against EXE/MEM.
    function automatic int cycles_needed();
        if (branch_ID && mem_read_ID_EXE && dep(rd_ID_EXE)) return 2;
        if (mem_read_ID_EXE && dep(rd_ID_EXE)) return 1;
        if (branch_ID && wen_ID_EXE && dep(rd_ID_EXE)) return 1;
        if (branch_ID && mem_read_EXE_MEM && dep(rd_EXE_MEM)) return 1;
        return 0;
    endfunction

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        int  need;
        bit  st;
        if (!rst) begin
            m_extra = 0;
            m_cnt   = 0;
        end
        need = (m_extra > 0) ? 0 : cycles_needed();
        st   = (m_extra > 0) || (need > 0);
        check("pc_wen",        int'(pc_wen),        int'(!st));
        check("if_id_wen",     int'(if_id_wen),     int'(!st));
        check("bubble_ID_EXE", int'(bubble_ID_EXE), int'(st));
        check("flush_IF_ID",   int'(flush_IF_ID),   int'(take_branch && !st));
        check("stall_cycles",  int'(stall_cycles),  m_cnt);
        if (!rst) begin
            n_extra = 0;
            n_cnt   = 0;
        end else begin
            n_extra = (m_extra > 0) ? m_extra - 1 : need - 1;
            if (n_extra < 0) n_extra = 0;
            if (cnt_clr)     n_cnt = 0;
            else if (st)     n_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            else             n_cnt = m_cnt;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_extra = 0;
            m_cnt   = 0;
        end else begin
            m_extra = n_extra;
            m_cnt   = n_cnt;
        end
    end

    task automatic idle();
        rs_IF_ID = '0; rt_IF_ID = '0; rd_ID_EXE = '0; rd_EXE_MEM = '0;
        wen_ID_EXE = 1'b0; mem_read_ID_EXE = 1'b0; mem_read_EXE_MEM = 1'b0;
        branch_ID = 1'b0; take_branch = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2 rst = 1'b0;
        repeat (2) tick();
        settle();
        check("reset pc_wen",    int'(pc_wen),        1);
        check("reset if_id_wen", int'(if_id_wen),     1);
        check("reset bubble",    int'(bubble_ID_EXE), 0);
        check("reset flush",     int'(flush_IF_ID),   0);
        check("reset count",     int'(stall_cycles),  0);

        // Load-use on rt.
        tick(); rst = 1'b1;
        mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd3; rt_IF_ID = 5'd3;
        settle();
        check("loaduse pc_wen", int'(pc_wen),        0);
        check("loaduse bubble", int'(bubble_ID_EXE), 1);
        tick(); idle();
        settle();
        check("loaduse after pc_wen", int'(pc_wen),       1);
        check("loaduse count",        int'(stall_cycles), 1);

        // Clear, then a load into r0 must not stall.
        tick(); cnt_clr = 1'b1;
        tick(); cnt_clr = 1'b0;
        mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd0; rt_IF_ID = 5'd0;
        settle();
        check("zero-reg pc_wen", int'(pc_wen),       1);
        check("zero-reg count",  int'(stall_cycles), 0);
        tick(); idle();
        settle();
        check("zero-reg count after", int'(stall_cycles), 0);

        // Branch on a load in EXE: two stall cycles, taken ignored in the second.
        tick();
        branch_ID = 1'b1; mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd5; rs_IF_ID = 5'd5;
        settle();
        check("brload c1 pc_wen", int'(pc_wen), 0);
        tick(); idle(); take_branch = 1'b1;
        settle();
        check("brload c2 pc_wen", int'(pc_wen),      0);
        check("brload c2 flush",  int'(flush_IF_ID), 0);
        tick();
        settle();
        check("brload run pc_wen", int'(pc_wen),       1);
        check("brload run flush",  int'(flush_IF_ID),  1);
        check("brload count",      int'(stall_cycles), 2);
        tick(); idle();
        settle();
        check("flush one cycle", int'(flush_IF_ID), 0);

        // Reset during the STALL cycle.
        tick();
        branch_ID = 1'b1; mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd5; rs_IF_ID = 5'd5;
        tick(); idle();
        settle();
        check("midstall pc_wen", int'(pc_wen),       0);
        check("midstall count",  int'(stall_cycles), 3);
        rst = 1'b0;
        #1;
        check("rst abort pc_wen", int'(pc_wen),        1);
        check("rst abort bubble", int'(bubble_ID_EXE), 0);
        check("rst abort count",  int'(stall_cycles),  0);
        tick(); rst = 1'b1;
        tick();
        settle();
        check("post-rst pc_wen", int'(pc_wen),       1);
        check("post-rst count",  int'(stall_cycles), 0);

        // Saturation, then clear while still stalling.
        tick();
        mem_read_ID_EXE = 1'b1; rd_ID_EXE = 5'd7; rs_IF_ID = 5'd7;
        repeat (20) tick();
        settle();
        check("saturated count", int'(stall_cycles), 15);
        tick(); cnt_clr = 1'b1;
        tick(); cnt_clr = 1'b0;
        check("clear count", int'(stall_cycles), 0);
        tick();
        check("resume count", int'(stall_cycles), 1);
        idle();

        // Randomized traffic with small register indices to provoke matches.
        repeat (3000) begin
            tick();
            rst              = ($urandom_range(0, 99) != 0);
            rs_IF_ID         = 5'($urandom_range(0, 3));
            rt_IF_ID         = 5'($urandom_range(0, 3));
            rd_ID_EXE        = 5'($urandom_range(0, 3));
            rd_EXE_MEM       = 5'($urandom_range(0, 3));
            wen_ID_EXE       = 1'($urandom_range(0, 1));
            mem_read_ID_EXE  = ($urandom_range(0, 9) < 4);
            mem_read_EXE_MEM = ($urandom_range(0, 9) < 4);
            branch_ID        = 1'($urandom_range(0, 1));
            take_branch      = 1'($urandom_range(0, 1));
            cnt_clr          = ($urandom_range(0, 11) == 0);
        end
        tick(); rst = 1'b1; idle();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

`default_nettype wire
